// File: rtl/svmrow_acc_multi.sv
// Sliding-window SVM row accumulator: raster features are MAC'd against one coefficient
// set over NWIN overlapping windows, then bias-adjusted scores drain through ready/valid.
module svmrow_acc_multi #(
    parameter int DWIDTH    = 8,
    parameter int CWIDTH    = 9,
    parameter int AWIDTH    = 32,
    parameter int BLOCKSIZE = 8,
    parameter int WINCOLS   = 8,
    parameter int WINROWS   = 16,
    parameter int NWIN      = 8,
    localparam int LINEW    = (NWIN - 1 + WINCOLS) * BLOCKSIZE,
    localparam int WINW     = WINCOLS * BLOCKSIZE,
    localparam int CAW      = $clog2(WINROWS * WINW),
    localparam int WIW      = (NWIN > 1) ? $clog2(NWIN) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DWIDTH-1:0]        data,
    input  logic                     dvi,
    output logic                     in_ready,
    input  logic                     coef_we,
    input  logic [CAW-1:0]           coef_addr,
    input  logic signed [CWIDTH-1:0] coef_data,
    input  logic signed [AWIDTH-1:0] bias,
    input  logic signed [AWIDTH-1:0] threshold,
    output logic signed [AWIDTH-1:0] svm_data,
    output logic                     det,
    output logic [WIW-1:0]           win_idx,
    output logic                     dvo,
    input  logic                     out_ready,
    output logic                     done,
    output logic                     err
);
    // state  | meaning
    // ACCUM  | accepting pixels, MAC lanes active
    // FLUSH  | two cycles letting the multiply/accumulate pipeline empty
    // DRAIN  | presenting one window score per handshake
    // FIN    | done pulse, clear accumulators and counters
    typedef enum logic [1:0] {ACCUM, FLUSH, DRAIN, FIN} state_t;

    localparam int PW    = DWIDTH + CWIDTH + 1;
    localparam int SW    = ((AWIDTH > PW) ? AWIDTH : PW) + 1;
    localparam int COLW  = $clog2(LINEW);
    localparam int ROWW  = (WINROWS > 1) ? $clog2(WINROWS) : 1;
    localparam int BLKW  = $clog2(NWIN - 1 + WINCOLS);
    localparam int BOFFW = $clog2(WINROWS * BLOCKSIZE);
    localparam int BANKW = (WINCOLS > 1) ? $clog2(WINCOLS) : 1;

    function automatic logic signed [AWIDTH-1:0] sat(input logic signed [SW-1:0] v);
        if ((&v[SW-1:AWIDTH-1]) || !(|v[SW-1:AWIDTH-1])) return v[AWIDTH-1:0];
        else if (v[SW-1])                                return {1'b1, {(AWIDTH-1){1'b0}}};
        else                                             return {1'b0, {(AWIDTH-1){1'b1}}};
    endfunction

    state_t                   state_q;
    logic [COLW-1:0]          col_q;
    logic [ROWW-1:0]          row_q;
    logic                     flush_q;
    logic                     in_ready_q, dvo_q, done_q, err_q, det_q;
    logic [WIW-1:0]           win_idx_q;
    logic signed [AWIDTH-1:0] svm_data_q, bias_q, thr_q;
    logic signed [AWIDTH-1:0] acc_q [NWIN];
    logic signed [AWIDTH-1:0] acc_d [NWIN];
    logic signed [PW-1:0]     prod_q [WINCOLS];
    logic [BLKW-1:0]          p_blk_q;
    logic                     p_valid_q;

    logic signed [CWIDTH-1:0] coef_mem [WINCOLS][WINROWS*BLOCKSIZE];
    logic [BANKW-1:0]         wr_bank;
    logic [BOFFW-1:0]         wr_off, rd_off;
    logic                     accept;

    // Bank k holds columns k*BLOCKSIZE.. of every row, so every lane reads its own bank.
    assign wr_bank = BANKW'((coef_addr % WINW) / BLOCKSIZE);
    assign wr_off  = BOFFW'((coef_addr / WINW) * BLOCKSIZE + coef_addr % BLOCKSIZE);
    assign rd_off  = BOFFW'(row_q * BLOCKSIZE + col_q % BLOCKSIZE);
    assign accept  = dvi && in_ready_q;

    always_ff @(posedge clk) begin
        if (coef_we) coef_mem[wr_bank][wr_off] <= coef_data;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < WINCOLS; k++)
                prod_q[k] <= PW'($signed({1'b0, data})) * PW'(coef_mem[k][rd_off]);
            p_blk_q <= BLKW'(col_q / BLOCKSIZE);
        end
    end

    // Lane k of the current block belongs to window blk-k; each window picks its one lane.
    always_comb begin
        logic signed [PW-1:0] sel;
        logic                 hit;
        for (int w = 0; w < NWIN; w++) begin
            acc_d[w] = acc_q[w];
            sel = '0;
            hit = 1'b0;
            for (int k = 0; k < WINCOLS; k++) begin
                if (p_valid_q && (int'(p_blk_q) - k == w)) begin
                    sel = prod_q[k];
                    hit = 1'b1;
                end
            end
            if (hit) acc_d[w] = sat(SW'(acc_q[w]) + SW'(sel));
        end
    end

    logic [WIW-1:0]           sc_idx;
    logic signed [AWIDTH-1:0] sc_bias, sc_thr, score;
    logic                     sc_det;

    assign sc_idx  = (state_q == FLUSH) ? '0 : win_idx_q + 1'b1;
    assign sc_bias = (state_q == FLUSH) ? bias : bias_q;
    assign sc_thr  = (state_q == FLUSH) ? threshold : thr_q;
    assign score   = sat(SW'(acc_q[sc_idx]) + SW'(sc_bias));
    assign sc_det  = score > sc_thr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ACCUM;
            col_q      <= '0;
            row_q      <= '0;
            flush_q    <= 1'b0;
            in_ready_q <= 1'b1;
            dvo_q      <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            det_q      <= 1'b0;
            win_idx_q  <= '0;
            svm_data_q <= '0;
            bias_q     <= '0;
            thr_q      <= '0;
            p_valid_q  <= 1'b0;
            for (int w = 0; w < NWIN; w++) acc_q[w] <= '0;
        end else begin
            p_valid_q <= accept;
            if (dvi && !in_ready_q) err_q <= 1'b1;
            for (int w = 0; w < NWIN; w++) acc_q[w] <= (state_q == FIN) ? '0 : acc_d[w];

            case (state_q)
                ACCUM: if (accept) begin
                    if (col_q == COLW'(LINEW - 1)) begin
                        col_q <= '0;
                        if (row_q == ROWW'(WINROWS - 1)) begin
                            row_q      <= '0;
                            state_q    <= FLUSH;
                            in_ready_q <= 1'b0;
                            flush_q    <= 1'b1;
                        end else begin
                            row_q <= row_q + 1'b1;
                        end
                    end else begin
                        col_q <= col_q + 1'b1;
                    end
                end
                FLUSH: if (flush_q == 1'b0) begin
                    state_q    <= DRAIN;
                    bias_q     <= bias;
                    thr_q      <= threshold;
                    win_idx_q  <= '0;
                    svm_data_q <= score;
                    det_q      <= sc_det;
                    dvo_q      <= 1'b1;
                end else begin
                    flush_q <= flush_q - 1'b1;
                end
                DRAIN: if (out_ready) begin
                    if (win_idx_q == WIW'(NWIN - 1)) begin
                        state_q    <= FIN;
                        dvo_q      <= 1'b0;
                        done_q     <= 1'b1;
                        win_idx_q  <= '0;
                        svm_data_q <= '0;
                        det_q      <= 1'b0;
                    end else begin
                        win_idx_q  <= win_idx_q + 1'b1;
                        svm_data_q <= score;
                        det_q      <= sc_det;
                    end
                end
                FIN: begin
                    done_q     <= 1'b0;
                    col_q      <= '0;
                    row_q      <= '0;
                    in_ready_q <= 1'b1;
                    state_q    <= ACCUM;
                end
                default: state_q <= ACCUM;
            endcase
        end
    end

    assign in_ready = in_ready_q;
    assign svm_data = svm_data_q;
    assign det      = det_q;
    assign win_idx  = win_idx_q;
    assign dvo      = dvo_q;
    assign done     = done_q;
    assign err      = err_q;
endmodule

// File: tb/tb_svmrow_acc_multi.sv
// Bench for svmrow_acc_multi: directed frames against a raster-order window model,
// checked on every output cycle for a 32-bit and a 16-bit accumulator instance.
module tb_svmrow_acc_multi;
    localparam int NWIN = 8, WINROWS = 16, WINCOLS = 8, BS = 8;
    localparam int LINEW = (NWIN - 1 + WINCOLS) * BS;
    localparam int WINW  = WINCOLS * BS;
    localparam int NCOEF = WINROWS * WINW;

    logic clk = 1'b0, reset = 1'b1;
    logic [7:0] data = '0;
    logic dvi = 1'b0, coef_we = 1'b0, out_ready = 1'b1;
    logic [9:0] coef_addr = '0;
    logic signed [8:0] coef_data = '0;
    logic signed [31:0] bias = '0, threshold = '0, svm_data;
    logic signed [15:0] bias2 = '0, thr2 = '0, svm_data2;
    logic in_ready, det, dvo, done, err;
    logic in_ready2, det2, dvo2, done2, err2;
    logic [2:0] win_idx, win_idx2;

    always #5 clk = ~clk;

    svmrow_acc_multi u_dut (
        .clk(clk), .reset(reset), .data(data), .dvi(dvi), .in_ready(in_ready),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .bias(bias), .threshold(threshold), .svm_data(svm_data), .det(det),
        .win_idx(win_idx), .dvo(dvo), .out_ready(out_ready), .done(done), .err(err));

    svmrow_acc_multi #(.AWIDTH(16)) u_dut16 (
        .clk(clk), .reset(reset), .data(data), .dvi(dvi), .in_ready(in_ready2),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .bias(bias2), .threshold(thr2), .svm_data(svm_data2), .det(det2),
        .win_idx(win_idx2), .dvo(dvo2), .out_ready(out_ready), .done(done2), .err(err2));

    typedef struct { longint score; bit det; int idx; } exp_t;
    exp_t q1[$], q2[$];
    int cmem [NCOEF];
    int pix [WINROWS][LINEW];
    int n_pass = 0, n_tot = 0, done_cnt = 0;
    logic prev_done = 1'b0;

    function automatic void chk(string nm, longint got, longint want);
        n_tot++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, got, want);
    endfunction

    function automatic longint clampv(longint v, int aw);
        longint lim = longint'(1) <<< (aw - 1);
        if (v > lim - 1) return lim - 1;
        if (v < -lim) return -lim;
        return v;
    endfunction

    // Window w covers columns w*BS .. w*BS+WINW-1 of every row, summed in raster order.
    function automatic longint model_acc(int w, int aw);
        longint a = 0;
        for (int r = 0; r < WINROWS; r++)
            for (int x = 0; x < WINW; x++)
                a = clampv(a + longint'(pix[r][w*BS+x] * cmem[r*WINW+x]), aw);
        return a;
    endfunction

    task automatic push_exp(input longint b, input longint t);
        longint s;
        for (int w = 0; w < NWIN; w++) begin
            s = clampv(model_acc(w, 32) + b, 32);
            q1.push_back('{s, (s > t), w});
            s = clampv(model_acc(w, 16) + b, 16);
            q2.push_back('{s, (s > t), w});
        end
        bias = 32'(b); threshold = 32'(t);
        bias2 = 16'(b); thr2 = 16'(t);
    endtask

    task automatic fill_coef(input int v, input bit rnd);
        for (int a = 0; a < NCOEF; a++) cmem[a] = rnd ? int'($urandom_range(0, 511)) - 256 : v;
    endtask

    task automatic fill_pix(input int v, input bit rnd);
        for (int r = 0; r < WINROWS; r++)
            for (int c = 0; c < LINEW; c++) pix[r][c] = rnd ? int'($urandom_range(0, 255)) : v;
    endtask

    task automatic load_coefs();
        for (int a = 0; a < NCOEF; a++) begin
            coef_we = 1'b1; coef_addr = 10'(a); coef_data = 9'(cmem[a]);
            @(posedge clk); #1;
        end
        coef_we = 1'b0;
    endtask

    task automatic send_pix(input logic [7:0] v);
        int guard = 0;
        while (!in_ready && guard < 100) begin @(posedge clk); #1; guard++; end
        if (!in_ready) begin chk("in_ready_timeout", 0, 1); return; end
        data = v; dvi = 1'b1;
        @(posedge clk); #1;
        dvi = 1'b0;
    endtask

    task automatic stream(input bit gaps, input int abort_row, input bit poke);
        for (int r = 0; r < WINROWS; r++)
            for (int c = 0; c < LINEW; c++) begin
                if (r == abort_row && c == 10) return;
                if (gaps && ((r * LINEW + c) % 7 == 3)) begin @(posedge clk); #1; end
                send_pix(8'(pix[r][c]));
            end
        if (poke) begin
            data = 8'hFF; dvi = 1'b1;
            @(posedge clk); #1;
            dvi = 1'b0;
        end
    endtask

    task automatic drain(input int stall_len, input bit poke);
        int start = done_cnt, guard = 0, stall_left = stall_len;
        while (done_cnt == start && guard < 400) begin
            if (stall_left > 0 && dvo && win_idx == 3'd3) begin out_ready = 1'b0; stall_left--; end
            else out_ready = 1'b1;
            if (poke && dvo && win_idx < 3'd3) begin dvi = 1'b1; data = 8'hAA; end
            else dvi = 1'b0;
            @(posedge clk); #1; guard++;
        end
        out_ready = 1'b1; dvi = 1'b0;
        chk("done_seen", done_cnt - start, 1);
        chk("q1_empty", q1.size(), 0);
        chk("q2_empty", q2.size(), 0);
        if (stall_len > 0) chk("stall_applied", stall_left, 0);
    endtask

    always @(negedge clk) begin
        if (dvo) begin
            if (q1.size() == 0) chk("dvo_unexpected", 1, 0);
            else begin
                chk("svm_data", longint'(svm_data), q1[0].score);
                chk("det", det, q1[0].det);
                chk("win_idx", win_idx, q1[0].idx);
                if (out_ready) void'(q1.pop_front());
            end
        end
        if (dvo2) begin
            if (q2.size() == 0) chk("dvo16_unexpected", 1, 0);
            else begin
                chk("svm_data16", longint'(svm_data2), q2[0].score);
                chk("det16", det2, q2[0].det);
                chk("win_idx16", win_idx2, q2[0].idx);
                if (out_ready) void'(q2.pop_front());
            end
        end
        if (done || done2) chk("done16_align", done2, done);
        if (done) begin
            chk("done_width", prev_done, 0);
            chk("done_after_last", q1.size(), 0);
            done_cnt++;
        end
        prev_done = done;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int saved;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_dvo", dvo, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_svm_data", svm_data, 0);
        chk("rst_win_idx", win_idx, 0);
        chk("rst_det", det, 0);
        chk("rst_in_ready16", in_ready2, 1);
        chk("rst_err16", err2, 0);
        @(posedge clk); #1;

        // all ones: every window sums 1024, bias -24 gives 1000
        fill_coef(1, 0); load_coefs(); fill_pix(1, 0);
        chk("model_ones", model_acc(0, 32), 1024);
        push_exp(-24, 999);
        chk("exp_ones_score", q1[0].score, 1000);
        stream(0, -1, 0); drain(0, 0);

        // same frame with input bubbles and a 5-cycle stall at window 3
        push_exp(-24, 999);
        stream(1, -1, 0); drain(5, 0);

        // single tap: window 0 sees 3*5, others nothing
        fill_coef(0, 0); cmem[0] = 5; load_coefs();
        fill_pix(0, 0); pix[0][0] = 3;
        chk("model_single_w0", model_acc(0, 32), 15);
        chk("model_single_w1", model_acc(1, 32), 0);
        push_exp(0, 0);
        stream(0, -1, 0); drain(0, 0);

        // saturation of the 16-bit instance
        fill_coef(255, 0); load_coefs(); fill_pix(255, 0);
        chk("model_sat16", model_acc(3, 16), 32767);
        chk("model_sat32", model_acc(3, 32), 66585600);
        push_exp(0, 0);
        stream(0, -1, 0); drain(0, 0);

        // dvi during FLUSH and DRAIN is dropped and flags err
        fill_pix(0, 1); push_exp(100, 5000);
        stream(0, -1, 1); drain(0, 1);
        chk("err_set", err, 1);
        chk("err16_set", err2, 1);
        repeat (3) @(posedge clk); #1;
        chk("err_sticky", err, 1);

        // reset partway into row 5
        fill_coef(0, 1); load_coefs(); fill_pix(0, 1);
        saved = done_cnt;
        stream(0, 5, 0);
        reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        chk("abort_dvo", dvo, 0);
        chk("abort_done", done, 0);
        chk("abort_err", err, 0);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_win_idx", win_idx, 0);
        @(posedge clk); #1;
        chk("abort_no_done", done_cnt, saved);
        load_coefs(); push_exp(-37, 12000);
        stream(0, -1, 0); drain(0, 0);

        // back-to-back random frames sharing one coefficient set
        fill_coef(0, 1); load_coefs();
        fill_pix(0, 1); push_exp(int'($urandom_range(0, 2000)) - 1000, 0);
        stream(0, -1, 0); drain(0, 0);
        fill_pix(0, 1); push_exp(int'($urandom_range(0, 2000)) - 1000, -500);
        stream(1, -1, 0); drain(3, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
